// File: rtl/alu_issue_stage.sv
// Issue stage for the 8-bit combinational ALU: buffers commands in a small FIFO,
// presents the head to the ALU and captures the result into a handshaked output slot.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [2:0]                 in_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_ctrl,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [2:0]                 out_op,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [2:0] OpUndef = 3'b111;

    logic [WIDTH-1:0] mem_a  [DEPTH];
    logic [WIDTH-1:0] mem_b  [DEPTH];
    logic [2:0]       mem_op [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [2:0]       out_op_q, out_op_d;
    logic             out_err_q, out_err_d;

    logic             not_empty;
    logic             push;
    logic             pop;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < DepthCnt);
    assign push      = in_valid && in_ready;
    // The slot is free when empty or being consumed this cycle.
    assign pop       = not_empty && (!out_valid_q || out_ready);

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (not_empty) begin
            alu_a    = mem_a[rd_ptr_q];
            alu_b    = mem_b[rd_ptr_q];
            alu_ctrl = mem_op[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_err_d    = out_err_q;
        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_op_d     = alu_ctrl;
            out_err_d    = (alu_ctrl == OpUndef);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Storage is not reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]  <= in_a;
            mem_b[wr_ptr_q]  <= in_b;
            mem_op[wr_ptr_q] <= in_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= '0;
            out_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;
    assign out_err    = out_err_q;
    assign level      = count_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the 8-bit combinational ALU (ports a, b, ctrl, result).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU inputs and captures the ALU result into a registered output slot with its own valid/ready handshake.
- Decouples command producers from result consumers; sustains one op per cycle under no backpressure.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous assert, active-high.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  ALU opcode, passed to ALU ctrl.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_ctrl  output  3  to ALU ctrl.
- alu_result  input  WIDTH  from ALU result; combinational in alu_a, alu_b and alu_ctrl.
- out_valid  output  1  captured result available.
- out_ready  input  1  consumer takes result.
- out_result  output  WIDTH  captured ALU result.
- out_op  output  3  opcode that produced out_result.
- out_err  output  1  opcode was 3'b111, which the ALU does not define.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO pointers and count clear to 0; FIFO contents are discarded.
  - out_valid, out_result, out_op and out_err clear to 0.
  - in_ready reads 1 once rst deasserts.
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_op} at the write pointer.
  - in_ready = (count < DEPTH); it is a function of count only.
  - No same-cycle push into a full FIFO, even if a pop occurs that cycle.
- ALU drive:
  - alu_a, alu_b and alu_ctrl equal the FIFO head entry whenever count > 0.
  - They read all zeros when count == 0.
  - They are purely combinational from registered state.
- Pop condition: count > 0 && (!out_valid || out_ready).
- On pop at a rising edge:
  - out_result <= alu_result.
  - out_op <= head op.
  - out_err <= (head op == 3'b111).
  - out_valid <= 1.
  - The read pointer advances.
- Opcode 3'b111 is still issued to the ALU; its captured result is unspecified, flagged only via out_err.
- Drain without pop: out_valid && out_ready && count == 0 → out_valid <= 0. out_result and out_op hold their last values.
- Stall: out_valid && !out_ready → out_result, out_op and out_err hold; no pop occurs.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH; count distinguishes full from empty.
- Latency: a command accepted at edge k appears on out_* after edge k+1 if the slot is free. Minimum latency is 2 edges from acceptance.
- Throughput: 1 result per cycle with out_ready held high.
- Ordering: strict FIFO; results leave in acceptance order.
- level = count.

Test Plan:
- Bench ALU stub for all scenarios: result = (a + b + ctrl) mod 256.
- Reset then single op: a=24, b=20, op=0 → level=1 after edge 1; out_valid=1, out_result=44, out_op=0, out_err=0 after edge 2; out_valid=0 one edge after out_ready pulse.
- Streaming: ops 0..6 with a=24, b=20, out_ready=1 → out_result 44, 45, 46, 47, 48, 49, 50 on consecutive cycles; in_ready stays 1.
- Backpressure/full: out_ready=0, push 5 commands at DEPTH=4 → 1 captured in the output slot, level reaches 4, in_ready=0 and the 6th push is refused. Raising out_ready drains all 5 in order with no loss or duplication.
- Simultaneous push/pop at level=2 with out_ready=1 → level stays 2 and the pointers wrap past DEPTH-1 correctly.
- Opcode 7: a=1, b=2, op=7 → out_err=1, out_op=7; the next op=0 command gives out_err=0.
- Async reset mid-stream: assert rst between edges with level=3 and out_valid=1 → level, out_valid and out_result read 0 immediately; no stale result appears after rst deasserts.
